// File: rtl/lms_train_gen.sv
// lms_train_gen: PRBS training source for the LMS filter.
// A 16-bit LFSR makes a +/-AMP symbol stream. The stream goes through a fixed
// 4-tap channel FIR to form x_out. A delayed copy of the symbol forms d_out.
// Each start delivers BURST_LEN (x_out, d_out) pairs over valid/ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        burst control (start sampled in IDLE only)
//   out_ready           downstream accepts the presented pair
//   out_valid           x_out/d_out hold a valid pair
//   x_out, d_out        signed channel output / desired symbol
//   busy, done          RUN indicator / one-cycle end-of-burst pulse
//   sample_cnt          pairs loaded in the current burst
module lms_train_gen #(
    parameter int unsigned        BURST_LEN = 1000,
    parameter logic signed [15:0] AMP       = 16'sd8192,
    parameter logic        [15:0] SEED      = 16'hACE1,
    parameter logic signed [15:0] H0        = 16'sd16384,
    parameter logic signed [15:0] H1        = 16'sd0,
    parameter logic signed [15:0] H2        = 16'sd0,
    parameter logic signed [15:0] H3        = 16'sd0,
    parameter int unsigned        DELAY     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               out_ready,
    output logic               out_valid,
    output logic signed [15:0] x_out,
    output logic signed [15:0] d_out,
    output logic               busy,
    output logic               done,
    output logic [9:0]         sample_cnt
);

    localparam logic [9:0] BL   = 10'(BURST_LEN);
    localparam logic [1:0] DSEL = 2'(DELAY);

    localparam logic signed [33:0] SAT_HI = 34'sd32767;
    localparam logic signed [33:0] SAT_LO = -34'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic        [15:0] lfsr_q, lfsr_d;
    logic signed [15:0] s_q [4];
    logic signed [15:0] s_d [4];
    logic        [9:0]  cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic signed [15:0] x_q, x_d;
    logic signed [15:0] dq_q, dq_d;

    logic               fb;
    logic               load;
    logic               xfer;
    logic signed [15:0] sym_new;
    logic signed [15:0] s_sh [4];
    logic signed [31:0] p0, p1, p2, p3;
    logic signed [33:0] acc;
    logic signed [33:0] sh;
    logic signed [15:0] x_sat;

    assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign sym_new = lfsr_q[0] ? AMP : -AMP;
    assign xfer    = valid_q && out_ready;

    // A new pair may be produced when the output slot is empty or is being
    // emptied this cycle; abort discards any pending load.
    assign load = (state_q == ST_RUN) && (!valid_q || out_ready)
                  && (cnt_q < BL) && !abort;

    // Symbol line as it will look after this load's shift.
    always_comb begin
        s_sh[0] = sym_new;
        s_sh[1] = s_q[0];
        s_sh[2] = s_q[1];
        s_sh[3] = s_q[2];
    end

    // Channel FIR on post-shift symbols, Q1.14 taps, saturated to 16 bits.
    always_comb begin
        p0  = H0 * s_sh[0];
        p1  = H1 * s_sh[1];
        p2  = H2 * s_sh[2];
        p3  = H3 * s_sh[3];
        acc = {{2{p0[31]}}, p0} + {{2{p1[31]}}, p1}
            + {{2{p2[31]}}, p2} + {{2{p3[31]}}, p3};
        sh  = acc >>> 14;
        if (sh > SAT_HI) begin
            x_sat = 16'sh7FFF;
        end else if (sh < SAT_LO) begin
            x_sat = -16'sh8000;
        end else begin
            x_sat = sh[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        x_d     = x_q;
        dq_d    = dq_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_RUN;
                    lfsr_d  = SEED;
                    s_d     = '{default: '0};
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    lfsr_d  = {lfsr_q[14:0], fb};
                    s_d     = s_sh;
                    x_d     = x_sat;
                    dq_d    = s_sh[DSEL];
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 10'd1;
                end else if (xfer && (cnt_q == BL)) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over start and over any pending transfer; data outputs
        // keep their last values.
        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            s_q     <= '{default: '0};
            cnt_q   <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            dq_q    <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            dq_q    <= dq_d;
        end
    end

    assign out_valid  = valid_q;
    assign x_out      = x_q;
    assign d_out      = dq_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = cnt_q;

endmodule

// File: doc/lms_train_gen.md
Name: lms_train_gen

Overview:
Training-sequence source for the LMS adaptive filter. It is the transmit end that feeds the filter's x/d sample inputs.
- Generates a PRBS bipolar symbol stream from a 16-bit LFSR.
- Passes the stream through a fixed 4-tap FIR model of the channel to form x_out.
- Emits a delayed copy of the raw symbol as the desired signal d_out.
- Delivers BURST_LEN (x, d) pairs per start, over a valid/ready handshake with backpressure.

Parameters:
BURST_LEN, 1000, number of sample pairs per burst (1..1023)
AMP, 16'sd8192, symbol magnitude; symbol = +AMP or -AMP
SEED, 16'hACE1, LFSR load value on start (must be nonzero)
H0, 16'sd16384, channel tap 0, signed Q1.14
H1, 16'sd0, channel tap 1, signed Q1.14
H2, 16'sd0, channel tap 2, signed Q1.14
H3, 16'sd0, channel tap 3, signed Q1.14
DELAY, 0, d_out tap select into symbol line (0..3)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a burst; sampled only in IDLE
abort  in  1  terminate burst; valid in any state
out_ready  in  1  downstream (LMS) can accept a pair
out_valid  out  1  x_out/d_out hold a valid pair
x_out  out  16  signed channel-model output
d_out  out  16  signed desired (delayed symbol)
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last pair accepted
sample_cnt  out  10  pairs loaded so far in current burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, x_out=0, d_out=0, busy=0, done=0, sample_cnt=0; LFSR=SEED; symbol line s0..s3=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1 and abort=0, load LFSR=SEED, clear s0..s3 and sample_cnt, go to RUN.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- LFSR: Fibonacci, fb = L[15]^L[13]^L[12]^L[10]. Advance: L <= {L[14:0], fb}.
- Load event in RUN: (!out_valid || out_ready) and sample_cnt < BURST_LEN. On a load event:
  - new symbol = L[0] ? +AMP : -AMP, taken from the current L; L then advances.
  - Symbol line shifts: s3<=s2, s2<=s1, s1<=s0, s0<=new.
  - x_out <= sat16((H0*s0' + H1*s1' + H2*s2' + H3*s3') >>> 14), where primes denote the post-shift values.
  - Products are 32-bit signed; the sum is 34-bit; >>> is an arithmetic shift (truncate toward -inf).
  - sat16 clamps to [-32768, 32767].
  - d_out <= s[DELAY]' (post-shift).
  - out_valid <= 1; sample_cnt++.
- Latency: start high at edge k moves to RUN; the first pair appears with out_valid=1 after edge k+1.
- Handshake:
  - Transfer occurs on a cycle with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, x_out/d_out/out_valid hold stable and the LFSR does not advance.
  - With out_ready held high, one pair per clock.
- End of burst: when sample_cnt==BURST_LEN and the last pair transfers, out_valid<=0 and the FSM goes to DONE. Exactly BURST_LEN transfers occur per burst.
- abort=1 in any state: next state IDLE; out_valid<=0, busy<=0; no done pulse; abort has priority over start and over a pending transfer. Outputs x_out/d_out keep their last values.
- start while in RUN or DONE is ignored.
- Zero-initialised symbol line: the first 3 x_out values include zero history (channel fill-in), by design.
- rst_n deasserted mid-burst: immediate return to reset values; a new start is required.

Test Plan:
1. Defaults (H0=16384, others 0, DELAY=0), out_ready=1, start pulse -> first three pairs x_out=d_out=16'h2000 (LFSR ACE1->59C3->B387, bit0=1 each); out_valid continuous for 1000 cycles; done pulses once; sample_cnt=1000.
2. Saturation: H0..H3=16384, AMP=16384, DELAY=3 -> x_out sequence 16'h4000, 7FFF, 7FFF, 7FFF. d_out sequence 0, 0, 0, 16'h4000.
3. Backpressure: out_ready low for 5 cycles after first valid -> x_out/d_out/out_valid unchanged for those cycles; the following pairs equal the scenario-1 sequence with no symbol skipped or duplicated.
4. Abort at sample 10 with out_ready=1 -> out_valid=0 and busy=0 next cycle, no done. A new start replays the sequence from 16'h2000 (SEED reloaded).
5. BURST_LEN=4 with random out_ready -> exactly 4 transfers; done exactly one cycle after the 4th transfer; start during RUN has no effect.
6. rst_n pulsed low mid-burst -> all outputs zero immediately (asynchronous); the FSM stays IDLE until the next start.
